// File: rtl/tt_um_ccjiaa_edge_meter.sv
// rtl/tt_um_ccjiaa_edge_meter.sv - gated rising-edge frequency meter with valid/ack result latch
//
// Counts synchronized rising edges of ui_in[0] over a window of N clk cycles,
// N = BASE_WIN << win_sel. The saturating 8-bit count is latched on uo_out.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored)
//   ui_in    [0] sig  [1] arm  [2] ack  [3] unused  [4] cont  [7:5] win_sel
//   uo_out   result of the last completed window
//   uio_in   unused
//   uio_out  [0] valid  [1] ovf  [2] busy  [3] edge_p  [7:4] zero
//   uio_oe   constant 8'h0F
`timescale 1ns/1ps
module tt_um_ccjiaa_edge_meter #(
    parameter int BASE_WIN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [2:0]  sig_sync_q, sig_sync_d;   // [0]=s1 [1]=s2 [2]=s3 (history)
    logic [2:0]  arm_sync_q, arm_sync_d;
    logic [11:0] win_cnt_q,  win_cnt_d;
    logic [7:0]  edge_cnt_q, edge_cnt_d;
    logic        sat_q,      sat_d;
    logic [7:0]  result_q,   result_d;
    logic        ovf_q,      ovf_d;
    logic        valid_q,    valid_d;

    logic        edge_p;
    logic        arm_rise;
    logic        ack;
    logic        cont;
    logic [2:0]  win_sel;
    logic [11:0] win_len_m1;
    logic        cnt_full;
    logic [7:0]  cnt_next;
    logic        sat_next;
    logic        load;

    logic        unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[3]};

    assign ack     = ui_in[2];
    assign cont    = ui_in[4];
    assign win_sel = ui_in[7:5];

    assign edge_p   = sig_sync_q[1] & ~sig_sync_q[2];
    assign arm_rise = arm_sync_q[1] & ~arm_sync_q[2];

    // Reload value for the window counter; the counter runs N-1 down to 0.
    assign win_len_m1 = (12'(BASE_WIN) << win_sel) - 12'd1;

    // Count as it would stand after this cycle, including this cycle's edge.
    assign cnt_full = (edge_cnt_q == 8'hFF);
    assign cnt_next = (edge_p && !cnt_full) ? edge_cnt_q + 8'd1 : edge_cnt_q;
    assign sat_next = sat_q | (edge_p & cnt_full);

    always_comb begin
        state_d    = state_q;
        sig_sync_d = {sig_sync_q[1:0], ui_in[0]};
        arm_sync_d = {arm_sync_q[1:0], ui_in[1]};
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm_rise || cont) begin
                    state_d    = GATE;
                    win_cnt_d  = win_len_m1;
                    edge_cnt_d = 8'd0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                if (win_cnt_q == 12'd0) begin
                    load     = 1'b1;
                    result_d = cnt_next;
                    ovf_d    = sat_next;
                    if (cont) begin
                        // Back-to-back window: the edge seen this cycle already
                        // went into the closing result, so restart from zero.
                        win_cnt_d  = win_len_m1;
                        edge_cnt_d = 8'd0;
                        sat_d      = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        edge_cnt_d = cnt_next;
                        sat_d      = sat_next;
                    end
                end else begin
                    win_cnt_d  = win_cnt_q - 12'd1;
                    edge_cnt_d = cnt_next;
                    sat_d      = sat_next;
                end
            end
            default: state_d = IDLE;
        endcase

        // A result load takes priority over a coincident ack.
        if (load) begin
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sig_sync_q <= 3'b000;
            arm_sync_q <= 3'b000;
            win_cnt_q  <= 12'd0;
            edge_cnt_q <= 8'd0;
            sat_q      <= 1'b0;
            result_q   <= 8'd0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_sync_q <= sig_sync_d;
            arm_sync_q <= arm_sync_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign uo_out  = result_q;
    assign uio_out = {4'b0000, edge_p, (state_q == GATE), ovf_q, valid_q};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_ccjiaa_edge_meter.sv
// tb/tb_tt_um_ccjiaa_edge_meter.sv - scoreboard bench for tt_um_ccjiaa_edge_meter
`timescale 1ns/1ps
module tb_tt_um_ccjiaa_edge_meter;

    typedef struct {
        int res;
        int ovf;
        int busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sig, arm, ack, cont;
    logic [2:0] win_sel;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    exp_t  sb[$];
    int    n_cmp;
    int    n_mis;
    int    n_cur;
    int    sig_half;
    int    sig_ph;
    int    bcnt;
    bit    load_next;
    string phase;

    assign ui_in = {win_sel, cont, 1'b0, ack, arm, sig};

    tt_um_ccjiaa_edge_meter #(.BASE_WIN(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (8'h00),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    // Signal generator: toggles sig every sig_half cycles; 0 holds it low.
    always @(negedge clk) begin
        if (sig_half > 0) begin
            sig_ph++;
            if (sig_ph >= sig_half) begin
                sig_ph = 0;
                sig    = ~sig;
            end
        end else begin
            sig_ph = 0;
            sig    = 1'b0;
        end
    end

    // Output monitor: after n_cur busy cycles a result must appear.
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt      = 0;
            load_next = 1'b0;
        end else begin
            if (load_next) begin
                load_next = 1'b0;
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", uo_out, e.res);
                    chk("ovf", uio_out[1], e.ovf);
                    chk("valid", uio_out[0], 1);
                    chk("busy_after", uio_out[2], e.busy);
                end
            end
            if (uio_out[2]) begin
                bcnt++;
                if (bcnt == n_cur) begin
                    load_next = 1'b1;
                    bcnt      = 0;
                end
            end
        end
    end

    task automatic arm_pulse(input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        arm = 1'b1;
        while (!uio_out[2] && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) arm = 1'b0;
        end
        arm = 1'b0;
        chk(tag, lat, 3);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int ep;
        n_cmp = 0; n_mis = 0; sig_ph = 0; bcnt = 0; load_next = 1'b0;
        rst_n = 1'b0; sig = 1'b0; arm = 1'b0; ack = 1'b0; cont = 1'b0;
        win_sel = 3'd0; sig_half = 0; n_cur = 16; phase = "reset";
        repeat (3) @(negedge clk);
        chk("uo_out", uo_out, 0);
        chk("uio_out", uio_out, 0);
        chk("uio_oe", uio_oe, 8'h0F);
        rst_n = 1'b1;

        // Phase-independent count: rise every 8 over N=16
        phase = "count"; win_sel = 3'd0; n_cur = 16; sig_half = 4;
        repeat (5) @(negedge clk);
        sb.push_back('{2, 0, 0});
        arm_pulse("start_lat");
        wait_drain(100);

        // ack with no pending load clears valid
        phase = "ack_clr";
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("valid", uio_out[0], 0);
        chk("keep_result", uo_out, 2);

        // ack held across a load: load wins
        phase = "ack_coinc"; sig_half = 2;
        repeat (4) @(negedge clk);
        sb.push_back('{4, 0, 0});
        ack = 1'b1;
        arm_pulse("start_lat");
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!uio_out[2]) break;
        end
        ack = 1'b0;
        @(negedge clk);
        chk("valid_hold", uio_out[0], 1);
        chk("new_result", uo_out, 4);
        wait_drain(10);

        // Saturation: N=2048, rise every 2 cycles
        phase = "sat"; win_sel = 3'd7; n_cur = 2048; sig_half = 1;
        repeat (4) @(negedge clk);
        sb.push_back('{255, 1, 0});
        arm_pulse("start_lat");
        wait_drain(2200);

        // Continuous mode, N=32, rise every 4, ten windows
        phase = "cont"; win_sel = 3'd1; n_cur = 32; sig_half = 2;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) sb.push_back('{8, 0, (i < 9) ? 1 : 0});
        cont = 1'b1;
        run = 0; ep = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (uio_out[2]) begin
                run++;
                ep += int'(uio_out[3]);
            end else if (run > 0) begin
                break;
            end
            if (run == 300) cont = 1'b0;
        end
        cont = 1'b0;
        chk("busy_run", run, 320);
        chk("edge_sum", ep, 80);
        wait_drain(50);

        // arm pulses inside an N=64 window are ignored
        phase = "arm_in_gate"; win_sel = 3'd2; n_cur = 64; sig_half = 4;
        repeat (4) @(negedge clk);
        sb.push_back('{8, 0, 0});
        arm_pulse("start_lat");
        for (int p = 0; p < 2; p++) begin
            repeat (15) @(negedge clk);
            arm = 1'b1;
            repeat (2) @(negedge clk);
            arm = 1'b0;
        end
        wait_drain(100);
        repeat (8) @(negedge clk);
        chk("no_restart", uio_out[2], 0);

        // Reset halfway through an N=128 window
        phase = "reset_mid"; win_sel = 3'd3; n_cur = 128; sig_half = 4;
        repeat (4) @(negedge clk);
        arm_pulse("start_lat");
        repeat (60) @(negedge clk);
        sig_half = 0;
        rst_n = 1'b0;
        #1;
        chk("uo_out", uo_out, 0);
        chk("uio_out_lo", uio_out[3:0], 0);
        chk("uio_oe", uio_oe, 8'h0F);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sb.push_back('{0, 0, 0});
        arm_pulse("start_lat");
        wait_drain(200);

        phase = "end";
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
